// File: rtl/sisc_lsu.sv
// SISC load/store unit: in-order store buffer drained with a setup/strobe/release
// write pulse, and single-cycle loads that forward from the youngest buffered store.
module sisc_lsu #(
   parameter int SB_DEPTH = 4,
   parameter int AW       = 16,
   parameter int DW       = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic                      i_req_we,
   input  logic [AW-1:0]             i_req_addr,
   input  logic [DW-1:0]             i_req_wdata,
   output logic                      o_rsp_valid,
   output logic [DW-1:0]             o_rsp_data,
   output logic [AW-1:0]             o_dm_read_addr,
   input  logic [DW-1:0]             i_dm_read_data,
   output logic [AW-1:0]             o_dm_write_addr,
   output logic [DW-1:0]             o_dm_write_data,
   output logic                      o_dm_we,
   output logic [$clog2(SB_DEPTH):0] o_sb_count,
   output logic                      o_sb_empty
);

   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      D_IDLE    = 2'd0,
      D_SETUP   = 2'd1,
      D_STROBE  = 2'd2,
      D_RELEASE = 2'd3
   } drain_t;

   drain_t        r_state;
   logic [AW-1:0] r_sb_addr [SB_DEPTH];
   logic [DW-1:0] r_sb_data [SB_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_accept;
   logic          w_push;
   logic          w_load;
   logic          w_pop;
   logic          w_fwd_hit;
   logic [DW-1:0] w_fwd_data;
   logic [PW-1:0] w_idx;

   assign o_req_ready    = !i_rst && (r_count < CW'(SB_DEPTH));
   assign w_accept       = i_req_valid && o_req_ready;
   assign w_push         = w_accept && i_req_we;
   assign w_load         = w_accept && !i_req_we;
   assign w_pop          = (r_state == D_RELEASE);
   assign o_dm_read_addr = i_req_addr;
   assign o_sb_count     = r_count;
   assign o_sb_empty     = (r_count == {CW{1'b0}});

   // Forwarding search: walk oldest to youngest so the last hit is the youngest store.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = {DW{1'b0}};
      w_idx      = r_rptr;
      for (int i = 0; i < SB_DEPTH; i++) begin
         w_idx = r_rptr + PW'(i);
         if ((CW'(i) < r_count) && (r_sb_addr[w_idx] == i_req_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_sb_data[w_idx];
         end else begin
            w_fwd_hit  = w_fwd_hit;
            w_fwd_data = w_fwd_data;
         end
      end
   end

   // Store-buffer entry storage and write pointer.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= {PW{1'b0}};
         for (int i = 0; i < SB_DEPTH; i++) begin
            r_sb_addr[i] <= {AW{1'b0}};
            r_sb_data[i] <= {DW{1'b0}};
         end
      end else if (w_push) begin
         r_sb_addr[r_wptr] <= i_req_addr;
         r_sb_data[r_wptr] <= i_req_wdata;
         r_wptr            <= r_wptr + PW'(1);
      end
   end

   // Occupancy: a push and a pop in the same cycle cancel out.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= {CW{1'b0}};
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Drain FSM: write port is loaded on entry to D_SETUP so it is stable before the strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state         <= D_IDLE;
         r_rptr          <= {PW{1'b0}};
         o_dm_we         <= 1'b0;
         o_dm_write_addr <= {AW{1'b0}};
         o_dm_write_data <= {DW{1'b0}};
      end else begin
         case (r_state)
            D_IDLE: begin
               o_dm_we <= 1'b0;
               if (r_count != {CW{1'b0}}) begin
                  r_state         <= D_SETUP;
                  o_dm_write_addr <= r_sb_addr[r_rptr];
                  o_dm_write_data <= r_sb_data[r_rptr];
               end
            end
            D_SETUP: begin
               o_dm_we <= 1'b1;
               r_state <= D_STROBE;
            end
            D_STROBE: begin
               o_dm_we <= 1'b0;
               r_state <= D_RELEASE;
            end
            D_RELEASE: begin
               o_dm_we <= 1'b0;
               r_rptr  <= r_rptr + PW'(1);
               if (r_count > CW'(1)) begin
                  r_state         <= D_SETUP;
                  o_dm_write_addr <= r_sb_addr[r_rptr + PW'(1)];
                  o_dm_write_data <= r_sb_data[r_rptr + PW'(1)];
               end else begin
                  r_state <= D_IDLE;
               end
            end
            default: begin
               o_dm_we <= 1'b0;
               r_state <= D_IDLE;
            end
         endcase
      end
   end

   // Load response, one cycle after acceptance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= {DW{1'b0}};
      end else begin
         o_rsp_valid <= w_load;
         if (w_load) begin
            o_rsp_data <= w_fwd_hit ? w_fwd_data : i_dm_read_data;
         end
      end
   end

endmodule

// File: tb/tb_sisc_lsu.sv
// Randomized self-checking bench for sisc_lsu: program-order memory model,
// write-order queue, strobe-shape monitor and directed boundary scenarios.
module tb_sisc_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [15:0] dm_read_addr;
   logic [31:0] dm_read_data;
   logic [15:0] dm_write_addr;
   logic [31:0] dm_write_data;
   logic        dm_we;
   logic [2:0]  sb_count;
   logic        sb_empty;

   int n_cmp = 0;
   int n_err = 0;

   bit [31:0]   dmem    [0:65535];
   bit          wr_seen [0:65535];
   logic [31:0] prog_mem [logic [15:0]];
   logic [47:0] wq [$];

   logic        rsp_due = 1'b0;
   logic [31:0] rsp_exp = 32'h0;
   int          hi_run = 0;
   int          lo_run = 0;
   bit          seen_strobe = 1'b0;

   sisc_lsu #(.SB_DEPTH(4), .AW(16), .DW(32)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_rsp_valid    (rsp_valid),
      .o_rsp_data     (rsp_data),
      .o_dm_read_addr (dm_read_addr),
      .i_dm_read_data (dm_read_data),
      .o_dm_write_addr(dm_write_addr),
      .o_dm_write_data(dm_write_data),
      .o_dm_we        (dm_we),
      .o_sb_count     (sb_count),
      .o_sb_empty     (sb_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] preload(input logic [15:0] a);
      case (a)
         16'h0040: return 32'hCAFEF00D;
         16'h0060: return 32'h12345678;
         default:  return {16'hA5A5, a};
      endcase
   endfunction

   function automatic logic [31:0] mem_now(input logic [15:0] a);
      return wr_seen[a] ? dmem[a] : preload(a);
   endfunction

   function automatic logic [31:0] expect_rd(input logic [15:0] a);
      if (prog_mem.exists(a)) return prog_mem[a];
      return mem_now(a);
   endfunction

   assign dm_read_data = mem_now(dm_read_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Data memory commits on the rising edge of the write strobe, in store order.
   always @(posedge dm_we) begin
      if (wq.size() == 0) begin
         chk("wr_unexpected", 32'd1, 32'd0);
      end else begin
         chk("wr_addr", {16'h0, dm_write_addr}, {16'h0, wq[0][47:32]});
         chk("wr_data", dm_write_data, wq[0][31:0]);
         void'(wq.pop_front());
      end
      dmem[dm_write_addr]    = dm_write_data;
      wr_seen[dm_write_addr] = 1'b1;
   end

   // Per-cycle monitor: response timing/data, strobe shape, handshake, model update.
   always @(negedge clk) begin
      if (rst) begin
         rsp_due     = 1'b0;
         wq.delete();
         prog_mem.delete();
         hi_run      = 0;
         lo_run      = 0;
         seen_strobe = 1'b0;
      end else begin
         chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, rsp_due});
         if (rsp_valid && rsp_due) chk("rsp_data", rsp_data, rsp_exp);
         chk("req_ready", {31'h0, req_ready}, {31'h0, (sb_count < 3'd4)});
         chk("sb_empty", {31'h0, sb_empty}, {31'h0, (sb_count == 3'd0)});
         if (dm_we) begin
            if (hi_run == 0 && seen_strobe) chk("we_gap", {31'h0, (lo_run >= 2)}, 32'd1);
            hi_run++;
            lo_run = 0;
         end else begin
            if (hi_run > 0) begin
               chk("we_width", hi_run, 32'd1);
               seen_strobe = 1'b1;
            end
            hi_run = 0;
            lo_run++;
         end
         rsp_due = 1'b0;
         if (req_valid && req_ready) begin
            if (req_we) begin
               prog_mem[req_addr] = req_wdata;
               wq.push_back({req_addr, req_wdata});
            end else begin
               rsp_due = 1'b1;
               rsp_exp = expect_rd(req_addr);
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d, output int stalls);
      bit done;
      done   = 1'b0;
      stalls = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (req_ready) done = 1'b1;
         else stalls++;
         @(posedge clk);
         #1;
      end
      if (!done) chk("req_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (sb_empty) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = 16'h0;
      req_wdata = 32'h0;
      #1;
      chk("rst_sb_count", {29'h0, sb_count}, 32'd0);
      chk("rst_sb_empty", {31'h0, sb_empty}, 32'd1);
      chk("rst_dm_we", {31'h0, dm_we}, 32'd0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_wr_addr", {16'h0, dm_write_addr}, 32'd0);
      chk("rst_wr_data", dm_write_data, 32'd0);
      chk("rst_ready", {31'h0, req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single store: setup, one-cycle strobe, release, then empty.
      issue(1'b1, 16'h0010, 32'hDEADBEEF, st);
      @(negedge clk);
      chk("ss_count", {29'h0, sb_count}, 32'd1);
      chk("ss_idle_we", {31'h0, dm_we}, 32'd0);
      @(negedge clk);
      chk("ss_setup_we", {31'h0, dm_we}, 32'd0);
      chk("ss_setup_addr", {16'h0, dm_write_addr}, 32'h0010);
      chk("ss_setup_data", dm_write_data, 32'hDEADBEEF);
      @(negedge clk);
      chk("ss_strobe_we", {31'h0, dm_we}, 32'd1);
      chk("ss_strobe_addr", {16'h0, dm_write_addr}, 32'h0010);
      chk("ss_strobe_data", dm_write_data, 32'hDEADBEEF);
      @(negedge clk);
      chk("ss_release_we", {31'h0, dm_we}, 32'd0);
      chk("ss_release_cnt", {29'h0, sb_count}, 32'd1);
      chk("ss_release_addr", {16'h0, dm_write_addr}, 32'h0010);
      @(negedge clk);
      chk("ss_empty", {31'h0, sb_empty}, 32'd1);
      chk("ss_mem", dmem[16'h0010], 32'hDEADBEEF);
      wait_idle();

      // Forwarding picks the youngest of two matching stores.
      issue(1'b1, 16'h0020, 32'h11111111, st);
      issue(1'b1, 16'h0020, 32'h22222222, st);
      issue(1'b0, 16'h0020, 32'h0, st);
      @(negedge clk);
      chk("fwd_valid", {31'h0, rsp_valid}, 32'd1);
      chk("fwd_data", rsp_data, 32'h22222222);
      chk("fwd_count", {29'h0, sb_count}, 32'd2);
      @(negedge clk);
      chk("fwd_pulse", {31'h0, rsp_valid}, 32'd0);
      wait_idle();

      // Full stall: fifth store waits for the first release; pointers wrap.
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, 16'h0030 + 16'(i), 32'h30000000 + 32'(i), st);
         if (i == 3) chk("stall_4th", st, 32'd0);
         if (i == 4) chk("stall_5th", st, 32'd1);
      end
      wait_idle();
      for (int i = 0; i < 5; i++) chk("stall_mem", dmem[16'h0030 + 16'(i)], 32'h30000000 + 32'(i));

      // Load miss from preloaded memory.
      issue(1'b0, 16'h0040, 32'h0, st);
      @(negedge clk);
      chk("miss_valid", {31'h0, rsp_valid}, 32'd1);
      chk("miss_data", rsp_data, 32'hCAFEF00D);
      @(negedge clk);
      chk("miss_pulse", {31'h0, rsp_valid}, 32'd0);
      wait_idle();

      // Load accepted while the matching entry is in release.
      issue(1'b1, 16'h0050, 32'hAAAAAAAA, st);
      repeat (3) @(posedge clk);
      #1;
      chk("rel_count", {29'h0, sb_count}, 32'd1);
      issue(1'b0, 16'h0050, 32'h0, st);
      chk("rel_nostall", st, 32'd0);
      @(negedge clk);
      chk("rel_valid", {31'h0, rsp_valid}, 32'd1);
      chk("rel_data", rsp_data, 32'hAAAAAAAA);
      chk("rel_empty", {31'h0, sb_empty}, 32'd1);
      wait_idle();

      // Load ordered before a store to the same address returns the old value.
      issue(1'b0, 16'h0060, 32'h0, st);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h0060;
      req_wdata = 32'h87654321;
      @(negedge clk);
      chk("ord_valid", {31'h0, rsp_valid}, 32'd1);
      chk("ord_data", rsp_data, 32'h12345678);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_idle();
      chk("ord_mem", dmem[16'h0060], 32'h87654321);

      // Reset mid-drain with three entries queued and the strobe high.
      issue(1'b1, 16'h0070, 32'h70707070, st);
      issue(1'b1, 16'h0071, 32'h71717171, st);
      issue(1'b1, 16'h0072, 32'h72727272, st);
      @(negedge clk);
      chk("mr_strobe", {31'h0, dm_we}, 32'd1);
      chk("mr_count", {29'h0, sb_count}, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_dm_we", {31'h0, dm_we}, 32'd0);
      chk("mr_count0", {29'h0, sb_count}, 32'd0);
      chk("mr_empty", {31'h0, sb_empty}, 32'd1);
      chk("mr_rsp", {31'h0, rsp_valid}, 32'd0);
      chk("mr_ready", {31'h0, req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mr_committed", dmem[16'h0070], 32'h70707070);
      chk("mr_discarded", {31'h0, wr_seen[16'h0071]}, 32'd0);
      @(posedge clk);
      #1;

      // Randomized mix over a small address window to exercise forwarding.
      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
         end
         issue(1'($urandom_range(0, 1)), 16'h0080 + 16'($urandom_range(0, 5)), $urandom, st);
      end
      wait_idle();
      chk("rand_wq_empty", wq.size(), 32'd0);
      foreach (prog_mem[k]) chk("rand_final_mem", dmem[k], prog_mem[k]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sisc_lsu.md
Name: sisc_lsu

Overview:
- Load/store unit between the SISC execute stage and the data memory.
- Accepts one memory request per cycle over a valid/ready handshake.
- Stores are queued in a small in-order store buffer and drained to data memory with a clean setup/strobe/release write pulse; data memory commits on the rising edge of its write enable.
- Loads read data memory combinationally, forward the youngest matching buffered store, and return data one cycle after acceptance.

Parameters:
SB_DEPTH, 4, store-buffer entries; power of 2, minimum 2.
AW, 16, word-address width.
DW, 32, data width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  request accepted when req_valid && req_ready at the clk edge.
req_we  input  1  1 = store, 0 = load.
req_addr  input  AW  word address.
req_wdata  input  DW  store data.
rsp_valid  output  1  one-cycle pulse carrying load data.
rsp_data  output  DW  load result.
dm_read_addr  output  AW  data memory read address.
dm_read_data  input  DW  data memory read word.
dm_write_addr  output  AW  data memory write address.
dm_write_data  output  DW  data memory write word.
dm_we  output  1  data memory write strobe; memory writes on its rising edge.
sb_count  output  clog2(SB_DEPTH)+1  occupied store-buffer entries.
sb_empty  output  1  sb_count == 0.

Behaviour:
- Reset values, asserted asynchronously:
  - rsp_valid=0, rsp_data=0, dm_we=0, dm_write_addr=0, dm_write_data=0.
  - sb_count=0, sb_empty=1, drain FSM=D_IDLE, read/write pointers=0.
- req_ready = (sb_count < SB_DEPTH), for both loads and stores. It is 0 while rst=1.
  - A full buffer stalls all requests, even if a pop occurs that cycle. There is no full-pass-through.
- Store accept: push {req_addr, req_wdata} at the write pointer; sb_count increments.
  - Pointers are log2(SB_DEPTH) bits and wrap naturally.
- Load accept:
  - dm_read_addr = req_addr, combinationally, at all times.
  - At the accepting edge: rsp_data <= youngest valid buffer entry whose addr == req_addr; otherwise dm_read_data.
  - rsp_valid <= 1 for exactly the next cycle. Latency 1, back-to-back loads allowed.
  - Youngest means the entry closest to the write pointer, searched over the sb_count valid entries only.
- Drain FSM (one store in flight):
  - D_IDLE: if sb_count != 0, go to D_SETUP.
  - D_SETUP: dm_write_addr/dm_write_data <= head entry; dm_we=0. Next D_STROBE.
  - D_STROBE: dm_we <= 1; memory commits on this rising edge. Next D_RELEASE.
  - D_RELEASE: dm_we <= 0; pop head, sb_count decrements. Next D_SETUP if more than 1 entry remained, else D_IDLE.
  - dm_write_addr/dm_write_data are held stable from D_SETUP through D_RELEASE.
  - dm_we is registered (glitch-free); it is high for exactly 1 cycle, with at least 2 low cycles between strobes.
  - Throughput is one store per 3 cycles.
- Simultaneous push and pop in one cycle: sb_count is unchanged; the new entry lands at the write pointer.
- Load in the same cycle as D_RELEASE for a matching entry:
  - The entry still counts as valid for forwarding; memory already holds the same value. Either source gives an identical result.
- Load in the same cycle a matching store is accepted: no forwarding from the same-cycle store. The load returns the older value (program order: load first).
- Reset mid-drain: dm_we drops immediately and buffered stores are discarded. A store whose dm_we rising edge already occurred remains committed in memory.
- The block never modifies addresses or data: no arithmetic, no byte lanes, word addressing only.

Test Plan:
- Reset/idle: assert rst mid-cycle with 3 entries queued and the FSM in D_STROBE.
  - Required: dm_we=0, sb_count=0, sb_empty=1, rsp_valid=0, all asynchronously.
- Single store: store addr 0x0010, data 0xDEADBEEF.
  - Required: D_SETUP, then dm_we high for 1 cycle with dm_write_addr=0x0010 and dm_write_data=0xDEADBEEF.
  - Required: memory word 0x0010 = 0xDEADBEEF; sb_empty returns to 1 three cycles after the drain starts.
- Forwarding: queue stores 0x0020 <- 0x11111111 then 0x0020 <- 0x22222222; immediately load 0x0020.
  - Required: rsp_valid 1 cycle later with rsp_data=0x22222222, before either store drains.
- Full stall: issue 5 back-to-back stores (0x0030..0x0034) with SB_DEPTH=4.
  - Required: req_ready=0 after the 4th; the 5th is accepted only after the first D_RELEASE.
  - Required: all five words are written in order; pointers wrap correctly.
- Load miss: memory preloaded with 0x0040=0xCAFEF00D, buffer empty, load 0x0040.
  - Required: rsp_data=0xCAFEF00D, rsp_valid for exactly 1 cycle.
- Same-cycle ordering: while the buffer holds 0x0050 <- 0xAAAAAAAA in D_RELEASE, load 0x0050.
  - Required: 0xAAAAAAAA.
  - Follow-up: issue a load of 0x0060 (memory 0x12345678) in the same cycle a store to 0x0060 is accepted. Required: 0x12345678.
